// File: rtl/iis_read_logic.sv
// iis_read_logic: I2S (Philips) master-mode receiver for a stereo ADC link.
// Divides clk_100m down to the bit clock and word select, shifts in serial
// data on rising bclk and presents the last complete left/right samples.
//
// Ports:
//   clk_100m  in   system clock, all logic on rising edge
//   rst_n     in   asynchronous reset, active HIGH despite the name
//   sdata_i   in   serial data, MSB first, changes on bclk falling edge
//   bclk      out  generated bit clock (registered)
//   lrclk     out  word select, 0 = left, 1 = right (registered)
//   ldata_l   out  last complete left sample
//   rdata_l   out  last complete right sample
module iis_read_logic #(
    parameter int unsigned BCLK_HALF = 16,
    parameter int unsigned DATA_W    = 24,
    parameter int unsigned SLOT_W    = 32
) (
    input  logic              clk_100m,
    input  logic              rst_n,
    input  logic              sdata_i,
    output logic              bclk,
    output logic              lrclk,
    output logic [DATA_W-1:0] ldata_l,
    output logic [DATA_W-1:0] rdata_l
);

    localparam int unsigned DIV_W     = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int unsigned SLOT_BITS = $clog2(2 * SLOT_W);

    localparam logic [DIV_W-1:0]     DIV_LAST  = DIV_W'(BCLK_HALF - 1);
    localparam logic [SLOT_BITS-1:0] SLOT_MAX  = SLOT_BITS'(2 * SLOT_W - 1);
    localparam logic [SLOT_BITS-1:0] SLOT_HALF = SLOT_BITS'(SLOT_W);
    localparam logic [SLOT_BITS-1:0] L_FIRST   = SLOT_BITS'(1);
    localparam logic [SLOT_BITS-1:0] L_LAST    = SLOT_BITS'(DATA_W);
    localparam logic [SLOT_BITS-1:0] R_FIRST   = SLOT_BITS'(SLOT_W + 1);
    localparam logic [SLOT_BITS-1:0] R_LAST    = SLOT_BITS'(SLOT_W + DATA_W);

    logic [DIV_W-1:0]     div_cnt;
    logic [SLOT_BITS-1:0] slot;
    // Only DATA_W-1 bits are kept: the final bit goes straight into the output latch.
    logic [DATA_W-2:0]    shift;

    logic                 div_wrap_c;
    logic                 rise_c;
    logic                 fall_c;
    logic                 in_left_c;
    logic                 in_right_c;
    logic [SLOT_BITS-1:0] slot_next_c;
    logic [DATA_W-1:0]    word_c;

    // Event decode: a divider wrap toggles bclk, its current level tells the direction.
    always_comb begin
        div_wrap_c  = (div_cnt == DIV_LAST);
        rise_c      = div_wrap_c & ~bclk;
        fall_c      = div_wrap_c & bclk;
        in_left_c   = (slot >= L_FIRST) && (slot <= L_LAST);
        in_right_c  = (slot >= R_FIRST) && (slot <= R_LAST);
        slot_next_c = (slot == SLOT_MAX) ? '0 : slot + SLOT_BITS'(1);
        word_c      = {shift, sdata_i};
    end

    // Clock generation, framing and capture.
    always_ff @(posedge clk_100m or posedge rst_n) begin
        if (rst_n) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
            lrclk   <= 1'b0;
            slot    <= '0;
            shift   <= '0;
            ldata_l <= '0;
            rdata_l <= '0;
        end else begin
            div_cnt <= div_wrap_c ? '0 : div_cnt + DIV_W'(1);

            if (div_wrap_c) begin
                bclk <= ~bclk;
            end

            // lrclk follows the new slot so it changes together with the bclk fall.
            if (fall_c) begin
                slot  <= slot_next_c;
                lrclk <= (slot_next_c >= SLOT_HALF);
            end

            // Slot 0 and the padding slots are the I2S delay / unused bits: ignored.
            if (rise_c && (in_left_c || in_right_c)) begin
                shift <= word_c[DATA_W-2:0];
            end

            if (rise_c && (slot == L_LAST)) begin
                ldata_l <= word_c;
            end

            if (rise_c && (slot == R_LAST)) begin
                rdata_l <= word_c;
            end
        end
    end

endmodule

// File: tb/tb_iis_read_logic.sv
// Testbench for iis_read_logic: arithmetic timing model plus a per-slot bit
// record that rebuilds the expected samples, checked every clock.
`timescale 1ns/1ps
module tb_iis_read_logic;

    localparam int DATA_W = 24;
    localparam int SLOT_W = 32;
    localparam int HALF   = 16;
    localparam int BIT    = 32;
    localparam int FRAME  = 2048;

    logic              clk_100m;
    logic              rst;
    logic              sdata_i;
    logic              bclk;
    logic              lrclk;
    logic [DATA_W-1:0] ldata_l;
    logic [DATA_W-1:0] rdata_l;

    iis_read_logic #(.BCLK_HALF(HALF), .DATA_W(DATA_W), .SLOT_W(SLOT_W)) dut (
        .clk_100m (clk_100m),
        .rst_n    (rst),
        .sdata_i  (sdata_i),
        .bclk     (bclk),
        .lrclk    (lrclk),
        .ldata_l  (ldata_l),
        .rdata_l  (rdata_l)
    );

    initial clk_100m = 1'b0;
    always #5 clk_100m = ~clk_100m;

    int tests;
    int fails;
    int n;
    int ms;
    int ds;
    logic              cmp_en;
    logic              frame_bits [64];
    logic [DATA_W-1:0] exp_l;
    logic [DATA_W-1:0] exp_r;
    logic [DATA_W-1:0] cur_l;
    logic [DATA_W-1:0] cur_r;
    logic              pad_bit;
    logic              rand_mode;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] word_from(input int first);
        logic [DATA_W-1:0] w;
        w = '0;
        for (int i = 0; i < DATA_W; i++) w = {w[DATA_W-2:0], frame_bits[first+i]};
        return w;
    endfunction

    // Model: n = clock edges since reset release; bit k of a slot is sampled mid-slot.
    always @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            n     = 0;
            exp_l = '0;
            exp_r = '0;
        end else begin
            n = n + 1;
            if (n % BIT == HALF) begin
                ms = (n / BIT) % 64;
                frame_bits[ms] = sdata_i;
                if (ms == DATA_W)          exp_l = word_from(1);
                if (ms == SLOT_W + DATA_W) exp_r = word_from(SLOT_W + 1);
            end
        end
    end

    // Driver: new bit at the start of each slot (just after bclk falls).
    always @(negedge clk_100m) begin
        if (n % BIT == 0) begin
            ds = (n / BIT) % 64;
            if (rand_mode)
                sdata_i = 1'($urandom);
            else if (ds >= 1 && ds <= DATA_W)
                sdata_i = cur_l[DATA_W-ds];
            else if (ds >= SLOT_W + 1 && ds <= SLOT_W + DATA_W)
                sdata_i = cur_r[SLOT_W+DATA_W-ds];
            else
                sdata_i = pad_bit;
        end
    end

    // Compare every clock, away from the active edge.
    always @(negedge clk_100m) begin
        if (cmp_en) begin
            check("bclk", 32'(bclk), 32'((n / HALF) % 2));
            check("lrclk", 32'(lrclk), 32'(((n / BIT) % 64) >= SLOT_W));
            check("ldata_l", 32'(ldata_l), 32'(exp_l));
            check("rdata_l", 32'(rdata_l), 32'(exp_r));
        end
    end

    task automatic wait_frame();
        int k;
        k = 0;
        do begin
            @(negedge clk_100m);
            k++;
        end while ((n % FRAME != 0) && (k < 3 * FRAME));
        if (k >= 3 * FRAME) begin
            tests++;
            fails++;
            $display("FAIL frame_wait: timed out after %0d cycles, required frame boundary", k);
        end
    endtask

    task automatic check_first_rise();
        int c;
        c = 0;
        while (c < 100) begin
            @(posedge clk_100m);
            #1;
            c++;
            if (bclk) break;
        end
        check("first_rise", 32'(c), 32'(HALF));
    endtask

    initial begin
        tests = 0; fails = 0; cmp_en = 1'b0;
        rst = 1'b1; sdata_i = 1'b0;
        cur_l = '0; cur_r = '0; pad_bit = 1'b0; rand_mode = 1'b0;
        repeat (3) @(negedge clk_100m);
        check("rst_bclk", 32'(bclk), 32'd0);
        check("rst_lrclk", 32'(lrclk), 32'd0);
        check("rst_ldata", 32'(ldata_l), 32'd0);
        check("rst_rdata", 32'(rdata_l), 32'd0);
        cmp_en = 1'b1;
        rst = 1'b0;
        check_first_rise();

        // Frame 0 idle.
        wait_frame();
        check("idle_ldata", 32'(ldata_l), 32'd0);
        check("idle_rdata", 32'(rdata_l), 32'd0);
        cur_l = 24'hA5A5A5; cur_r = 24'h3C0FF1;

        wait_frame();
        check("pat_ldata", 32'(ldata_l), 32'h00A5A5A5);
        check("pat_rdata", 32'(rdata_l), 32'h003C0FF1);
        cur_l = 24'h123456; cur_r = 24'h000000;

        wait_frame();
        check("seq0_ldata", 32'(ldata_l), 32'h00123456);
        cur_l = 24'hFEDCBA;
        repeat (20 * BIT) @(negedge clk_100m);
        check("seq_hold", 32'(ldata_l), 32'h00123456);

        wait_frame();
        check("seq1_ldata", 32'(ldata_l), 32'h00FEDCBA);
        cur_l = '0; cur_r = '0; pad_bit = 1'b1;

        wait_frame();
        check("pad_ldata", 32'(ldata_l), 32'd0);
        check("pad_rdata", 32'(rdata_l), 32'd0);
        rand_mode = 1'b1;

        for (int f = 0; f < 12; f++) wait_frame();
        rand_mode = 1'b0; pad_bit = 1'b0;
        cur_l = 24'h5A5A5A; cur_r = 24'h0F0F0F;

        // Reset in the middle of a right slot while bclk is high.
        repeat (40 * BIT + 20) @(negedge clk_100m);
        check("pre_rst_lrclk", 32'(lrclk), 32'd1);
        check("pre_rst_bclk", 32'(bclk), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_bclk", 32'(bclk), 32'd0);
        check("async_lrclk", 32'(lrclk), 32'd0);
        check("async_ldata", 32'(ldata_l), 32'd0);
        check("async_rdata", 32'(rdata_l), 32'd0);
        repeat (5) @(negedge clk_100m);
        rst = 1'b0;
        check_first_rise();

        wait_frame();
        check("restart_ldata", 32'(ldata_l), 32'h005A5A5A);
        check("restart_rdata", 32'(rdata_l), 32'h000F0F0F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
